// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM: fetch/decode/execute/memory/writeback sequencing,
// memory-stall timeout trap, illegal-opcode trap and retired-instruction counter. Macro: MCU_BEQ_EN.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter int unsigned RETIRE_CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [5:0]              op_code,
    input  logic [5:0]              funct,
    input  logic                    mem_ready,
    output logic                    pc_write,
    output logic                    pc_write_cond,
    output logic [1:0]              pc_source,
    output logic                    i_or_d,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic                    ir_write,
    output logic                    mem_to_reg,
    output logic                    reg_write,
    output logic                    reg_dst,
    output logic                    alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [1:0]              alu_op,
    output logic                    instr_done,
    output logic [RETIRE_CNT_W-1:0] instret,
    output logic                    illegal,
    output logic                    bus_err,
    output logic [3:0]              state
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_RD   = 4'd4,
        MEM_WB   = 4'd5,
        MEM_WR   = 4'd6,
        R_EXEC   = 4'd7,
        R_WB     = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        TRAP     = 4'd15
    } state_t;

    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            cur_state;
    state_t            nxt_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              stalled;
    logic              timeout;
    logic              set_illegal;

    assign state = cur_state;

    assign stalled = ((cur_state == FETCH) || (cur_state == MEM_RD) || (cur_state == MEM_WR))
                     && !mem_ready;
    // wait_cnt holds the number of earlier stalled cycles, so this is the MEM_TIMEOUT-th one
    assign timeout = (MEM_TIMEOUT != 0) && stalled && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= IDLE;
            wait_cnt  <= '0;
            instret   <= '0;
            illegal   <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            wait_cnt  <= (stalled && !timeout) ? wait_cnt + WAIT_W'(1) : '0;
            if (instr_done)
                instret <= instret + RETIRE_CNT_W'(1);
            if (set_illegal)
                illegal <= 1'b1;
            if (timeout)
                bus_err <= 1'b1;
        end
    end

    always_comb begin
        nxt_state     = cur_state;
        set_illegal   = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        instr_done    = 1'b0;

        case (cur_state)
            IDLE: nxt_state = FETCH;
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    nxt_state = DECODE;
                end else if (timeout) begin
                    nxt_state = TRAP;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                if ((op_code == 6'd0) && ((funct == 6'd32) || (funct == 6'd34)))
                    nxt_state = R_EXEC;
                else if ((op_code == 6'd35) || (op_code == 6'd43))
                    nxt_state = MEM_ADDR;
                else if (op_code == 6'd2)
                    nxt_state = JUMP;
`ifdef MCU_BEQ_EN
                else if (op_code == 6'd4)
                    nxt_state = BRANCH;
`endif
                else begin
                    nxt_state   = TRAP;
                    set_illegal = 1'b1;
                end
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt_state = (op_code == 6'd35) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready)
                    nxt_state = MEM_WB;
                else if (timeout)
                    nxt_state = TRAP;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                nxt_state  = FETCH;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    nxt_state  = FETCH;
                end else if (timeout) begin
                    nxt_state = TRAP;
                end
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = (funct == 6'd34) ? 2'b01 : 2'b00;
                nxt_state = R_WB;
            end
            R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                nxt_state  = FETCH;
            end
`ifdef MCU_BEQ_EN
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
                nxt_state     = FETCH;
            end
`endif
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
                nxt_state  = FETCH;
            end
            TRAP: nxt_state = TRAP;
            default: nxt_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (MEM_TIMEOUT=4, RETIRE_CNT_W=4): per-cycle state and
// control vector from a queue of expected steps, plus counter/trap flag checks.
module tb_multicycle_control;

    localparam int unsigned TB_TIMEOUT = 4;
    localparam int unsigned TB_RW      = 4;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MADDR  = 4'd3;
    localparam logic [3:0] S_MRD    = 4'd4;
    localparam logic [3:0] S_MWB    = 4'd5;
    localparam logic [3:0] S_MWR    = 4'd6;
    localparam logic [3:0] S_REXEC  = 4'd7;
    localparam logic [3:0] S_RWB    = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_JUMP   = 4'd10;
    localparam logic [3:0] S_TRAP   = 4'd15;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [5:0]       op_code = '0;
    logic [5:0]       funct = '0;
    logic             mem_ready = 1'b0;
    logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic             mem_to_reg, reg_write, reg_dst, alu_src_a, instr_done, illegal, bus_err;
    logic [1:0]       pc_source, alu_src_b, alu_op;
    logic [TB_RW-1:0] instret;
    logic [3:0]       state;
    logic [16:0]      obs_ctl;

    typedef struct {
        logic       rdy;
        logic [3:0] st;
    } rec_t;

    rec_t             sb[$];
    int unsigned      n_checks = 0;
    int unsigned      n_pass = 0;
    int unsigned      n_fail = 0;
    logic [TB_RW-1:0] exp_instret = '0;

    multicycle_control #(
        .MEM_TIMEOUT (TB_TIMEOUT),
        .RETIRE_CNT_W(TB_RW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op_code      (op_code),
        .funct        (funct),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .pc_source    (pc_source),
        .i_or_d       (i_or_d),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .mem_to_reg   (mem_to_reg),
        .reg_write    (reg_write),
        .reg_dst      (reg_dst),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .instr_done   (instr_done),
        .instret      (instret),
        .illegal      (illegal),
        .bus_err      (bus_err),
        .state        (state)
    );

    always #5 clk = ~clk;

    assign obs_ctl = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, instr_done};

    // Control outputs required in each state, taken from the state output table
    function automatic logic [16:0] exp_ctl(input logic [3:0] st, input logic [5:0] fn,
                                            input logic rdy);
        logic pcw, pcwc, iod, mr, mw, irw, m2r, rw, rd, asa, done;
        logic [1:0] psrc, asb, aop;
        {pcw, pcwc, iod, mr, mw, irw, m2r, rw, rd, asa, done} = '0;
        psrc = 2'b00;
        asb  = 2'b00;
        aop  = 2'b00;
        case (st)
            S_FETCH:  begin mr = 1'b1; asb = 2'b01; irw = rdy; pcw = rdy; end
            S_DECODE: asb = 2'b11;
            S_MADDR:  begin asa = 1'b1; asb = 2'b10; end
            S_MRD:    begin mr = 1'b1; iod = 1'b1; end
            S_MWB:    begin rw = 1'b1; m2r = 1'b1; done = 1'b1; end
            S_MWR:    begin mw = 1'b1; iod = 1'b1; done = rdy; end
            S_REXEC:  begin asa = 1'b1; aop = (fn == 6'd34) ? 2'b01 : 2'b00; end
            S_RWB:    begin rw = 1'b1; rd = 1'b1; done = 1'b1; end
            S_BRANCH: begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; psrc = 2'b01; done = 1'b1; end
            S_JUMP:   begin pcw = 1'b1; psrc = 2'b10; done = 1'b1; end
            default:  ;
        endcase
        return {pcw, pcwc, psrc, iod, mr, mw, irw, m2r, rw, rd, asa, asb, aop, done};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic rdy, input logic [3:0] st);
        rec_t r;
        r.rdy = rdy;
        r.st  = st;
        sb.push_back(r);
    endtask

    // Entered and left at posedge+1: each step drives mem_ready, then checks the current cycle
    task automatic drain();
        rec_t r;
        while (sb.size() > 0) begin
            r = sb.pop_front();
            mem_ready = r.rdy;
            #1;
            check($sformatf("state(exp %0d)", r.st), {28'd0, state}, {28'd0, r.st});
            check($sformatf("ctl(st %0d)", r.st), {15'd0, obs_ctl},
                  {15'd0, exp_ctl(r.st, funct, r.rdy)});
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        #1;
        check("rst_state", {28'd0, state}, 32'd0);
        check("rst_ctl", {15'd0, obs_ctl}, 32'd0);
        check("rst_instret", {28'd0, instret}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        @(posedge clk);
        #1;
        mem_ready   = 1'b0;
        rst_n       = 1'b1;
        exp_instret = '0;
        push(1'b0, S_IDLE);
    endtask

    task automatic exec_instr(input logic [5:0] op, input logic [5:0] fn,
                              input int unsigned fetch_stalls, input int unsigned mem_stalls);
        op_code = op;
        funct   = fn;
        for (int unsigned i = 0; i < fetch_stalls; i++) push(1'b0, S_FETCH);
        push(1'b1, S_FETCH);
        push(1'b0, S_DECODE);
        case (op)
            6'd0:  begin push(1'b0, S_REXEC); push(1'b0, S_RWB); end
            6'd35: begin
                push(1'b0, S_MADDR);
                for (int unsigned i = 0; i < mem_stalls; i++) push(1'b0, S_MRD);
                push(1'b1, S_MRD);
                push(1'b0, S_MWB);
            end
            6'd43: begin
                push(1'b0, S_MADDR);
                for (int unsigned i = 0; i < mem_stalls; i++) push(1'b0, S_MWR);
                push(1'b1, S_MWR);
            end
            6'd4:  push(1'b0, S_BRANCH);
            default: push(1'b0, S_JUMP);
        endcase
        drain();
        exp_instret++;
        check($sformatf("instret(op %0d)", op), {28'd0, instret}, {28'd0, exp_instret});
    endtask

    task automatic illegal_seq(input logic [5:0] op, input logic [5:0] fn);
        op_code = op;
        funct   = fn;
        push(1'b1, S_FETCH);
        push(1'b0, S_DECODE);
        push(1'b0, S_TRAP);
        push(1'b0, S_TRAP);
        drain();
        check("illegal_set", {31'd0, illegal}, 32'd1);
        check("illegal_no_bus_err", {31'd0, bus_err}, 32'd0);
        check("illegal_instret", {28'd0, instret}, {28'd0, exp_instret});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        #1;
        reset_dut();

        exec_instr(6'd0, 6'd32, 0, 0);   // add, zero-wait
        exec_instr(6'd35, 6'd0, 0, 3);   // lw, ready arrives on the last permitted cycle
        exec_instr(6'd0, 6'd34, 2, 0);   // sub with fetch stalls
        exec_instr(6'd43, 6'd0, 0, 0);   // sw, zero-wait
        exec_instr(6'd43, 6'd0, 1, 3);
        exec_instr(6'd2, 6'd0, 0, 0);    // j
`ifdef MCU_BEQ_EN
        exec_instr(6'd4, 6'd0, 0, 0);    // beq
`endif

        for (int k = 0; k < 16; k++) begin
            exec_instr(6'd2, 6'd0, 0, 0);
            if (exp_instret == '0) break;
        end
        check("instret_wrap", {28'd0, instret}, 32'd0);

        exec_instr(6'd0, 6'd32, 0, 0);
        op_code = 6'd35;
        funct   = 6'd0;
        push(1'b1, S_FETCH);
        push(1'b0, S_DECODE);
        push(1'b0, S_MADDR);
        push(1'b0, S_MRD);
        drain();
        check("pre_rst_state", {28'd0, state}, {28'd0, S_MRD});
        check("pre_rst_mem_read", {31'd0, mem_read}, 32'd1);
        reset_dut();                     // mid-MEM_RD reset

        exec_instr(6'd0, 6'd32, 0, 0);
        illegal_seq(6'd0, 6'd36);
        reset_dut();
`ifndef MCU_BEQ_EN
        illegal_seq(6'd4, 6'd0);
        reset_dut();
`endif

        exec_instr(6'd2, 6'd0, 0, 0);
        op_code = 6'd43;
        funct   = 6'd0;
        push(1'b1, S_FETCH);
        push(1'b0, S_DECODE);
        push(1'b0, S_MADDR);
        for (int unsigned i = 0; i < TB_TIMEOUT; i++) push(1'b0, S_MWR);
        push(1'b0, S_TRAP);
        push(1'b0, S_TRAP);
        drain();
        check("timeout_bus_err", {31'd0, bus_err}, 32'd1);
        check("timeout_no_illegal", {31'd0, illegal}, 32'd0);
        check("timeout_instret", {28'd0, instret}, {28'd0, exp_instret});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
